// File: rtl/eep_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eep_pkg
// Brief   : Shared widths, data typedefs and fetch FSM encoding for eep_fetch.
// Revision: 1.0 - initial release
// ============================================================================
package eep_pkg;

  localparam int C_REG_WIDTH   = 16;
  localparam int C_INSTR_WIDTH = 16;

  typedef logic [C_REG_WIDTH-1:0]   reg_t;
  typedef logic [C_INSTR_WIDTH-1:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/eep_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : eep_fetch_fifo
// Brief   : Two-entry shift FIFO; slot 0 is always the head, so the outputs
//           come straight from a register.
// Revision: 1.0 - initial release
// ============================================================================
module eep_fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;
  logic [1:0]       w_wr_idx;

  assign w_pop    = pop && (r_count != 2'd0);
  assign w_push   = push && ((r_count != 2'd2) || w_pop);
  assign w_wr_idx = r_count - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_mem0 <= r_mem1;
      end
      // A write into slot 0 must win over the shift above.
      if (w_push) begin
        if (w_wr_idx == 2'd0) begin
          r_mem0 <= din;
        end else begin
          r_mem1 <= din;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem0;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/eep_fetch.sv
`default_nettype none
// ============================================================================
// Module  : eep_fetch
// Brief   : Instruction fetch unit with a synchronous ROM and 2-entry buffer.
//           Optional perf counters enabled by macro EEP_FETCH_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module eep_fetch
  import eep_pkg::*;
#(
  parameter int                   REG_WIDTH   = C_REG_WIDTH,
  parameter int                   INSTR_WIDTH = C_INSTR_WIDTH,
  parameter logic [REG_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [REG_WIDTH-1:0]   pc,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  input  logic                   br_valid,
  input  logic [REG_WIDTH-1:0]   br_target,
  input  logic                   halt,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [REG_WIDTH-1:0]   instr_pc
`ifdef EEP_FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_count
`endif
);

  localparam int                   C_ENTRY_W = INSTR_WIDTH + REG_WIDTH;
  localparam logic [REG_WIDTH-1:0] C_PC_ONE  = {{(REG_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t         r_state;
  logic [REG_WIDTH-1:0] r_pc;
  logic [REG_WIDTH-1:0] r_inflight_pc;
  logic                 r_inflight;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic [1:0]           w_count;
  logic [C_ENTRY_W-1:0] w_head;

  // A redirect kills this edge's pop, push and issue so nothing stale survives.
  assign w_pop   = instr_valid && instr_ready && !br_valid;
  assign w_push  = r_inflight && !br_valid;
  assign w_issue = (r_state == ST_RUN) && !br_valid && !halt &&
                   (({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + C_PC_ONE;
      end
      if (br_valid) begin
        r_pc    <= br_target;
        r_state <= ST_RUN;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_RUN;
          ST_RUN:  if (halt) r_state <= ST_HALT;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  eep_fetch_fifo #(
    .WIDTH (C_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (br_valid),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({rom_data, r_inflight_pc}),
    .dout  (w_head),
    .count (w_count)
  );

  assign pc          = r_pc;
  assign instr_valid = (w_count != 2'd0);
  assign instr       = w_head[C_ENTRY_W-1 -: INSTR_WIDTH];
  assign instr_pc    = w_head[REG_WIDTH-1:0];

`ifdef EEP_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (w_issue) fetch_count <= fetch_count + 32'd1;
      if (instr_valid && !instr_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eep_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_eep_fetch
// Brief   : Directed self-checking bench for eep_fetch (default and 0xFFFE reset PC).
// Revision: 1.0 - initial release
// ============================================================================
module tb_eep_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc, pc2;
  logic [15:0] rom_data, rom_data2;
  logic        br_valid, br_valid2;
  logic [15:0] br_target, br_target2;
  logic        halt, halt2;
  logic        instr_valid, instr_valid2;
  logic        instr_ready, instr_ready2;
  logic [15:0] instr, instr2;
  logic [15:0] instr_pc, instr_pc2;
`ifdef EEP_FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_next;
  logic [15:0] frozen_pc;

  eep_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .rom_data    (rom_data),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .halt        (halt),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef EEP_FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  eep_fetch #(.RESET_PC(16'hFFFE)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc2),
    .rom_data    (rom_data2),
    .br_valid    (br_valid2),
    .br_target   (br_target2),
    .halt        (halt2),
    .instr_valid (instr_valid2),
    .instr_ready (instr_ready2),
    .instr       (instr2),
    .instr_pc    (instr_pc2)
`ifdef EEP_FETCH_PERF_EN
    ,
    .fetch_count (fetch_count2),
    .stall_count (stall_count2)
`endif
  );

  // Synchronous ROM model: ROM[i] = i + 0x100.
  always @(posedge clk) begin
    rom_data  <= pc + 16'h0100;
    rom_data2 <= pc2 + 16'h0100;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume the head this cycle and compare it with the next expected address.
  task automatic accept();
    logic [15:0] e_instr;
    e_instr = exp_next + 16'h0100;
    check("accept_valid", instr_valid, 1'b1);
    check("accept_pc", instr_pc, exp_next);
    check("accept_instr", instr, e_instr);
    exp_next = exp_next + 16'd1;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    instr_ready  = 1'b1;
    br_valid     = 1'b0;
    br_target    = 16'h0;
    halt         = 1'b0;
    instr_ready2 = 1'b1;
    br_valid2    = 1'b0;
    br_target2   = 16'h0;
    halt2        = 1'b0;
    exp_next     = 16'h0;
    frozen_pc    = 16'h0;

    repeat (3) tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    check("rst_pc2", pc2, 16'hFFFE);
`ifdef EEP_FETCH_PERF_EN
    check("rst_fetch_cnt", fetch_count, 32'd0);
    check("rst_stall_cnt", stall_count, 32'd0);
`endif

    // Release: IDLE, then first issue one cycle later, data two cycles after that.
    rst_n = 1'b1;
    tick();
    check("c1_pc", pc, 16'h0000);
    tick();
    check("c2_pc", pc, 16'h0001);
    check("c2_valid", instr_valid, 1'b0);
    check("c2_valid2", instr_valid2, 1'b0);
    tick();
    check("wrap_valid2", instr_valid2, 1'b1);
    check("wrap_pc_a", instr_pc2, 16'hFFFE);
    exp_next = 16'h0000;
    accept();
    check("wrap_pc_b", instr_pc2, 16'hFFFF);
    accept();
    check("wrap_pc_c", instr_pc2, 16'h0000);
    check("wrap_instr_c", instr2, 16'h0100);
    repeat (4) accept();

    // Back-pressure: head held, PC frozen two ahead of the head.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", instr_valid, 1'b1);
      check("stall_instr_pc", instr_pc, exp_next);
      check("stall_instr", instr, exp_next + 16'h0100);
      check("stall_pc", pc, exp_next + 16'd2);
      tick();
    end
    instr_ready = 1'b1;
    repeat (6) accept();

    // Redirect with a buffered entry and a fetch in flight.
    instr_ready = 1'b0;
    br_valid    = 1'b1;
    br_target   = 16'h0040;
    tick();
    br_valid = 1'b0;
    check("br_valid_drop", instr_valid, 1'b0);
    check("br_pc", pc, 16'h0040);
    tick();
    check("br_valid_drop2", instr_valid, 1'b0);
    instr_ready = 1'b1;
    tick();
    exp_next = 16'h0040;
    repeat (3) accept();

    // Halt and redirect together: redirect wins, fetching continues.
    halt      = 1'b1;
    br_valid  = 1'b1;
    br_target = 16'h0010;
    tick();
    halt     = 1'b0;
    br_valid = 1'b0;
    check("hb_valid", instr_valid, 1'b0);
    check("hb_pc", pc, 16'h0010);
    tick();
    check("hb_run_pc", pc, 16'h0011);
    tick();
    exp_next = 16'h0010;
    repeat (4) accept();

    // Halt alone: the buffer and in-flight fetch drain, PC stays put.
    frozen_pc = exp_next + 16'd2;
    halt = 1'b1;
    accept();
    accept();
    check("halt_drained", instr_valid, 1'b0);
    tick();
    check("halt_drained2", instr_valid, 1'b0);
    check("halt_pc", pc, frozen_pc);
    halt = 1'b0;
    tick();
    check("halt_stays", instr_valid, 1'b0);
    check("halt_pc2", pc, frozen_pc);
    br_valid  = 1'b1;
    br_target = 16'h0020;
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    exp_next = 16'h0020;
    repeat (2) accept();

    // Asynchronous reset in the middle of a cycle.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", instr_valid, 1'b0);
    check("arst_pc", pc, 16'h0000);
    check("arst_valid2", instr_valid2, 1'b0);
    check("arst_pc2", pc2, 16'hFFFE);
`ifdef EEP_FETCH_PERF_EN
    check("arst_fetch_cnt", fetch_count, 32'd0);
    check("arst_stall_cnt", stall_count, 32'd0);
`endif
    tick();
    check("arst_hold_valid", instr_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rel_pc", pc, 16'h0001);
    check("rel_valid", instr_valid, 1'b0);
    tick();
    check("rel_pc2", instr_pc2, 16'hFFFE);
    exp_next = 16'h0000;
    repeat (2) accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
